// File: rtl/vga_pkg.sv
// Shared constants for the VGA character timing generator.
// Holds the default 640x480@60 timing, derived line/frame totals, counter
// width and the character-cell geometry (8x8 cells, shift of 3).
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int CNT_W        = 10;
    localparam int CELL_SIZE    = 8;
    localparam int CELL_SHIFT   = 3;

    // True when lo <= cnt < hi.
    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// N-deep, W-wide shift register with an asynchronous reset value.
// Used to delay {hsync, vsync, blank} so they line up with pixel colour
// coming out of the character RAM/ROM pipeline. N = 0 is a straight wire.
//
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset; every stage loads RST_VAL
//   i_d     : data in
//   o_q     : data out, N clocks after i_d
module sync_delay_line #(
    parameter int             N       = 2,
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    generate
        if (N == 0) begin : g_bypass
            logic w_unused_clk;
            assign w_unused_clk = i_clk ^ i_rst_n;
            assign o_q = i_d;
        end else begin : g_shift
            logic [W-1:0] r_stage [N];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < N; i++) begin
                        r_stage[i] <= RST_VAL;
                    end
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < N; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[N-1];
        end
    endgenerate

endmodule

// File: rtl/vga_char_timing.sv
// VGA raster timing generator producing character-cell coordinates for the
// character display path, plus sync/blank delayed to match the display
// read latency.
//
// Optional feature macro: VGA_CHAR_TIMING_FRAME_CNT_EN adds a 16-bit
// frame counter output (frame_count) usable as a blink/update time base.
//
// Ports:
//   pixel_clock   : pixel clock, rising edge
//   reset         : asynchronous active-low reset
//   char_column   : h_cnt[9:3], 1 clock after the counter
//   char_line     : v_cnt[9:3], 1 clock after the counter
//   subchar_line  : v_cnt[2:0], 1 clock after the counter
//   subchar_pixel : h_cnt[2:0], 1 clock after the counter
//   active        : inside the visible area, aligned with the coordinates
//   vga_hsync     : horizontal sync, 1+SYNC_DLY clocks after the counter
//   vga_vsync     : vertical sync, 1+SYNC_DLY clocks after the counter
//   vga_blank     : outside visible area, 1+SYNC_DLY clocks after counter
//   frame_start   : one-clock pulse for h=0/v=0, aligned with coordinates
//   frame_count   : (optional) frames started since reset, wraps at 16 bits
module vga_char_timing
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   SYNC_DLY = 2          // 0..7; 0 bypasses the delay line
) (
    input  logic       pixel_clock,
    input  logic       reset,
    output logic [6:0] char_column,
    output logic [6:0] char_line,
    output logic [2:0] subchar_line,
    output logic [2:0] subchar_pixel,
    output logic       active,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_blank,
    output logic       frame_start
`ifdef VGA_CHAR_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_active;
    logic             w_at_origin;
    logic             w_hs_lvl;
    logic             w_vs_lvl;

    logic [6:0]       r_char_column;
    logic [6:0]       r_char_line;
    logic [2:0]       r_subchar_line;
    logic [2:0]       r_subchar_pixel;
    logic             r_active;
    logic             r_frame_start;
    logic             r_hs;
    logic             r_vs;
    logic             r_blank;
    logic [2:0]       w_pins;

    assign w_h_wrap    = (r_h_cnt == H_LAST);
    assign w_v_wrap    = (r_v_cnt == V_LAST);
    assign w_active    = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
    assign w_at_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_hs_lvl    = in_window(r_h_cnt, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
    assign w_vs_lvl    = in_window(r_v_cnt, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;

    // Raster counters: v advances only on the h wrap, so a simultaneous
    // h/v wrap takes both to zero on the same edge.
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    // Output register: coordinates are raw counter bits even in blanking;
    // consumers qualify them with active.
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            r_char_column   <= '0;
            r_char_line     <= '0;
            r_subchar_line  <= '0;
            r_subchar_pixel <= '0;
            r_active        <= 1'b0;
            r_frame_start   <= 1'b0;
            r_hs            <= ~SYNC_POL;
            r_vs            <= ~SYNC_POL;
            r_blank         <= 1'b1;
        end else begin
            r_char_column   <= r_h_cnt[CNT_W-1:CELL_SHIFT];
            r_char_line     <= r_v_cnt[CNT_W-1:CELL_SHIFT];
            r_subchar_line  <= r_v_cnt[CELL_SHIFT-1:0];
            r_subchar_pixel <= r_h_cnt[CELL_SHIFT-1:0];
            r_active        <= w_active;
            r_frame_start   <= w_at_origin;
            r_hs            <= w_hs_lvl;
            r_vs            <= w_vs_lvl;
            r_blank         <= ~w_active;
        end
    end

    sync_delay_line #(
        .N       (SYNC_DLY),
        .W       (3),
        .RST_VAL ({~SYNC_POL, ~SYNC_POL, 1'b1})
    ) u_sync_dly (
        .i_clk   (pixel_clock),
        .i_rst_n (reset),
        .i_d     ({r_hs, r_vs, r_blank}),
        .o_q     (w_pins)
    );

    assign char_column   = r_char_column;
    assign char_line     = r_char_line;
    assign subchar_line  = r_subchar_line;
    assign subchar_pixel = r_subchar_pixel;
    assign active        = r_active;
    assign frame_start   = r_frame_start;
    assign vga_hsync     = w_pins[2];
    assign vga_vsync     = w_pins[1];
    assign vga_blank     = w_pins[0];

`ifdef VGA_CHAR_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_count;

    // Counts on the same edge that raises frame_start, so the value seen
    // alongside the pulse already includes that frame.
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            r_frame_count <= '0;
        end else if (w_at_origin) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_vga_char_timing.sv
// Bench for vga_char_timing. DUT A uses the default 640x480 timing with a
// 2-clock sync delay; DUT B uses a reduced raster (96x106, sync delay 0) so
// full frames, vertical sync and frame wrap fit in a short run.
// Expected values are pushed into per-DUT queues keyed by the clock count
// since reset release; a monitor per DUT samples on the falling edge and
// pops/compares the entries due at that count.
module tb_vga_char_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    logic [6:0] a_col, a_line, b_col, b_line;
    logic [2:0] a_subl, a_subp, b_subl, b_subp;
    logic       a_act, a_hs, a_vs, a_blank, a_fs;
    logic       b_act, b_hs, b_vs, b_blank, b_fs;
`ifdef VGA_CHAR_TIMING_FRAME_CNT_EN
    logic [15:0] a_fc, b_fc;
`endif

    vga_char_timing dut_a (
        .pixel_clock   (clk),
        .reset         (rst_a),
        .char_column   (a_col),
        .char_line     (a_line),
        .subchar_line  (a_subl),
        .subchar_pixel (a_subp),
        .active        (a_act),
        .vga_hsync     (a_hs),
        .vga_vsync     (a_vs),
        .vga_blank     (a_blank),
        .frame_start   (a_fs)
`ifdef VGA_CHAR_TIMING_FRAME_CNT_EN
        ,
        .frame_count   (a_fc)
`endif
    );

    vga_char_timing #(
        .H_ACTIVE (64), .H_FP (8), .H_SYNC (16), .H_BP (8),
        .V_ACTIVE (96), .V_FP (3), .V_SYNC (2),  .V_BP (5),
        .SYNC_POL (1'b0), .SYNC_DLY (0)
    ) dut_b (
        .pixel_clock   (clk),
        .reset         (rst_b),
        .char_column   (b_col),
        .char_line     (b_line),
        .subchar_line  (b_subl),
        .subchar_pixel (b_subp),
        .active        (b_act),
        .vga_hsync     (b_hs),
        .vga_vsync     (b_vs),
        .vga_blank     (b_blank),
        .frame_start   (b_fs)
`ifdef VGA_CHAR_TIMING_FRAME_CNT_EN
        ,
        .frame_count   (b_fc)
`endif
    );

    // Field codes.
    localparam int F_FS = 0, F_ACT = 1, F_COL = 2, F_LINE = 3, F_SUBL = 4,
                   F_SUBP = 5, F_HS = 6, F_VS = 7, F_BLANK = 8,
                   F_HSCNT = 9, F_ACTCNT = 10, F_VSCNT = 11, F_FSCNT = 12,
                   F_FC = 13;

    typedef struct {
        int cyc;
        int fld;
        int val;
    } exp_t;

    exp_t q [2][$];
    int   cyc [2];
    int   acc [2][4];   // hsync-low, active, vsync-low, frame_start counts
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic string fname(input int f);
        case (f)
            F_FS:     return "frame_start";
            F_ACT:    return "active";
            F_COL:    return "char_column";
            F_LINE:   return "char_line";
            F_SUBL:   return "subchar_line";
            F_SUBP:   return "subchar_pixel";
            F_HS:     return "vga_hsync";
            F_VS:     return "vga_vsync";
            F_BLANK:  return "vga_blank";
            F_HSCNT:  return "hsync_low_count";
            F_ACTCNT: return "active_count";
            F_VSCNT:  return "vsync_low_count";
            F_FSCNT:  return "frame_start_count";
            default:  return "frame_count";
        endcase
    endfunction

    function automatic int fld(input int d, input int f);
        int r;
        r = 0;
        case (f)
            F_FS:    r = (d == 0) ? int'(a_fs)    : int'(b_fs);
            F_ACT:   r = (d == 0) ? int'(a_act)   : int'(b_act);
            F_COL:   r = (d == 0) ? int'(a_col)   : int'(b_col);
            F_LINE:  r = (d == 0) ? int'(a_line)  : int'(b_line);
            F_SUBL:  r = (d == 0) ? int'(a_subl)  : int'(b_subl);
            F_SUBP:  r = (d == 0) ? int'(a_subp)  : int'(b_subp);
            F_HS:    r = (d == 0) ? int'(a_hs)    : int'(b_hs);
            F_VS:    r = (d == 0) ? int'(a_vs)    : int'(b_vs);
            F_BLANK: r = (d == 0) ? int'(a_blank) : int'(b_blank);
            F_HSCNT, F_ACTCNT, F_VSCNT, F_FSCNT: r = acc[d][f - F_HSCNT];
`ifdef VGA_CHAR_TIMING_FRAME_CNT_EN
            F_FC:    r = (d == 0) ? int'(a_fc) : int'(b_fc);
`endif
            default: r = -1;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input int act_v, input int exp_v);
        n_checks++;
        if (act_v == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act_v, exp_v);
    endtask

    task automatic push(input int d, input int c, input int f, input int v);
        q[d].push_back('{cyc: c, fld: f, val: v});
    endtask

    task automatic monitor(input int d);
        exp_t e;
        logic rst_v;
        cyc[d] = 0;
        for (int i = 0; i < 4; i++) acc[d][i] = 0;
        forever begin
            @(negedge clk);
            rst_v = (d == 0) ? rst_a : rst_b;
            if (!rst_v) begin
                cyc[d] = 0;
                for (int i = 0; i < 4; i++) acc[d][i] = 0;
            end else begin
                cyc[d]++;
                if (fld(d, F_HS) == 0)  acc[d][0]++;
                if (fld(d, F_ACT) == 1) acc[d][1]++;
                if (fld(d, F_VS) == 0)  acc[d][2]++;
                if (fld(d, F_FS) == 1)  acc[d][3]++;
                while (q[d].size() > 0 && q[d][0].cyc <= cyc[d]) begin
                    e = q[d].pop_front();
                    if (e.cyc == cyc[d])
                        check($sformatf("%s.%s@%0d", (d == 0) ? "A" : "B",
                                        fname(e.fld), e.cyc),
                              fld(d, e.fld), e.val);
                    else
                        check($sformatf("missed_%0d", e.cyc), cyc[d], e.cyc);
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        bit reached;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);

        // ---- DUT A: default timing, sync delay 2 ----
        push(0, 1, F_FS, 1);   push(0, 1, F_COL, 0);  push(0, 1, F_LINE, 0);
        push(0, 1, F_ACT, 1);  push(0, 1, F_HS, 1);   push(0, 1, F_VS, 1);
        push(0, 1, F_BLANK, 1);
        push(0, 2, F_FS, 0);   push(0, 2, F_BLANK, 1);
        push(0, 3, F_BLANK, 0); push(0, 3, F_HS, 1);  push(0, 3, F_VS, 1);
        push(0, 518, F_COL, 64); push(0, 518, F_SUBP, 5);
        push(0, 518, F_LINE, 0); push(0, 518, F_SUBL, 0);
        push(0, 640, F_ACT, 1); push(0, 641, F_ACT, 0);
        push(0, 642, F_BLANK, 0); push(0, 643, F_BLANK, 1);
        push(0, 658, F_HS, 1); push(0, 659, F_HS, 0);
        push(0, 754, F_HS, 0); push(0, 755, F_HS, 1);
        push(0, 800, F_ACTCNT, 640); push(0, 800, F_HSCNT, 96);
        push(0, 801, F_ACT, 1); push(0, 801, F_SUBL, 1);
        push(0, 801, F_LINE, 0); push(0, 801, F_FS, 0);
        push(0, 1458, F_HS, 1); push(0, 1459, F_HS, 0);
        push(0, 1600, F_HSCNT, 192); push(0, 1600, F_ACTCNT, 1280);
        push(0, 1600, F_VSCNT, 0);   push(0, 1600, F_FSCNT, 1);

        // ---- DUT B: 96x106 raster, no sync delay ----
        push(1, 1, F_FS, 1);   push(1, 1, F_ACT, 1);  push(1, 1, F_COL, 0);
        push(1, 1, F_LINE, 0); push(1, 1, F_HS, 1);   push(1, 1, F_VS, 1);
        push(1, 1, F_BLANK, 0);
`ifdef VGA_CHAR_TIMING_FRAME_CNT_EN
        push(1, 1, F_FC, 1);
`endif
        push(1, 2, F_FS, 0);   push(1, 2, F_SUBP, 1);
        push(1, 64, F_ACT, 1); push(1, 65, F_ACT, 0); push(1, 65, F_BLANK, 1);
        push(1, 72, F_HS, 1);  push(1, 73, F_HS, 0);
        push(1, 88, F_HS, 0);  push(1, 89, F_HS, 1);
        push(1, 8030, F_COL, 7);   push(1, 8030, F_SUBP, 5);
        push(1, 8030, F_LINE, 10); push(1, 8030, F_SUBL, 3);
        push(1, 8030, F_ACT, 1);
        push(1, 9121, F_LINE, 11); push(1, 9121, F_SUBL, 7);
        push(1, 9121, F_ACT, 1);
        push(1, 9184, F_ACT, 1);   push(1, 9185, F_ACT, 0);
        push(1, 9217, F_ACT, 0);   push(1, 9217, F_LINE, 12);
        push(1, 9217, F_BLANK, 1);
        push(1, 9504, F_VS, 1);    push(1, 9505, F_VS, 0);
        push(1, 9696, F_VS, 0);    push(1, 9697, F_VS, 1);
        push(1, 10176, F_FS, 0);   push(1, 10176, F_LINE, 13);
        push(1, 10176, F_SUBL, 1); push(1, 10176, F_COL, 11);
        push(1, 10176, F_SUBP, 7); push(1, 10176, F_ACTCNT, 6144);
        push(1, 10176, F_VSCNT, 192); push(1, 10176, F_HSCNT, 1696);
        push(1, 10176, F_FSCNT, 1);
        push(1, 10177, F_FS, 1);   push(1, 10177, F_LINE, 0);
        push(1, 10177, F_COL, 0);  push(1, 10177, F_SUBL, 0);
        push(1, 10177, F_FSCNT, 2);
`ifdef VGA_CHAR_TIMING_FRAME_CNT_EN
        push(1, 10177, F_FC, 2);
`endif
        push(1, 10178, F_FS, 0);
        push(1, 20352, F_FSCNT, 2); push(1, 20352, F_ACTCNT, 12288);
        push(1, 20353, F_FS, 1);    push(1, 20353, F_FSCNT, 3);
`ifdef VGA_CHAR_TIMING_FRAME_CNT_EN
        push(1, 20353, F_FC, 3);
`endif
        push(1, 25193, F_LINE, 6);  push(1, 25193, F_SUBL, 2);
        push(1, 25193, F_COL, 5);   push(1, 25193, F_SUBP, 0);
        push(1, 25193, F_ACT, 1);

        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Run B to the middle of its third frame (line 50, pixel 40).
        reached = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            #1;
            if (cyc[1] >= 25193) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) begin
            n_checks++;
            $display("FAIL B.midframe_wait: got cycle %0d, expected 25193", cyc[1]);
        end

        // Asynchronous reset between clock edges; outputs must clear at once.
        rst_b = 1'b0;
        #1;
        check("B.rst_frame_start",   fld(1, F_FS),    0);
        check("B.rst_active",        fld(1, F_ACT),   0);
        check("B.rst_char_column",   fld(1, F_COL),   0);
        check("B.rst_char_line",     fld(1, F_LINE),  0);
        check("B.rst_subchar_line",  fld(1, F_SUBL),  0);
        check("B.rst_subchar_pixel", fld(1, F_SUBP),  0);
        check("B.rst_vga_hsync",     fld(1, F_HS),    1);
        check("B.rst_vga_vsync",     fld(1, F_VS),    1);
        check("B.rst_vga_blank",     fld(1, F_BLANK), 1);
`ifdef VGA_CHAR_TIMING_FRAME_CNT_EN
        check("B.rst_frame_count",   fld(1, F_FC),    0);
`endif

        repeat (3) @(negedge clk);
        push(1, 1, F_FS, 1);   push(1, 1, F_ACT, 1);  push(1, 1, F_COL, 0);
        push(1, 1, F_LINE, 0); push(1, 1, F_BLANK, 0);
`ifdef VGA_CHAR_TIMING_FRAME_CNT_EN
        push(1, 1, F_FC, 1);
`endif
        push(1, 2, F_FS, 0);
`ifdef VGA_CHAR_TIMING_FRAME_CNT_EN
        push(1, 10, F_FC, 65535);
`endif
        push(1, 97, F_LINE, 0); push(1, 97, F_SUBL, 1); push(1, 97, F_COL, 0);
`ifdef VGA_CHAR_TIMING_FRAME_CNT_EN
        push(1, 10177, F_FS, 1); push(1, 10177, F_FC, 0);
`endif
        #1;
        rst_b = 1'b1;

`ifdef VGA_CHAR_TIMING_FRAME_CNT_EN
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (cyc[1] >= 5) break;
        end
        force dut_b.r_frame_count = 16'hFFFF;
        @(negedge clk);
        #1;
        release dut_b.r_frame_count;
`endif

        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            #1;
            if (q[0].size() == 0 && q[1].size() == 0) break;
        end
        for (int d = 0; d < 2; d++) begin
            while (q[d].size() > 0) begin
                exp_t e;
                e = q[d].pop_front();
                n_checks++;
                $display("FAIL timeout_%0d.%s@%0d: got no sample, expected %0d",
                         d, fname(e.fld), e.cyc, e.val);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
